// File: rtl/enemy_spawn_ctrl.sv
// rtl/enemy_spawn_ctrl.sv - enemy tile map clear/spawn writer with live-enemy count
module enemy_spawn_ctrl #(
  parameter int                    DATA_WIDTH  = 3,
  parameter int                    ADDR_WIDTH  = 15,
  parameter int                    MAP_CELLS   = 192,
  parameter int                    SPAWN_A     = 0,
  parameter int                    SPAWN_B     = 7,
  parameter int                    SPAWN_C     = 15,
  parameter logic [DATA_WIDTH-1:0] SPAWN_CODE  = 3'd1,
  parameter int                    MAX_ENEMIES = 4,
  parameter int                    CNT_WIDTH   = 3
) (
  input  logic                  write_clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic                  spawn_req,
  input  logic                  kill,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  we,
  output logic                  busy,
  output logic                  spawn_ack,
  output logic                  spawn_fail,
  output logic [CNT_WIDTH-1:0]  enemy_count
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_CHECK, S_WRITE, S_FAIL} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(MAP_CELLS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(MAX_ENEMIES);

  state_t                state, state_d;
  logic [1:0]            rr_ptr, rr_ptr_d;
  logic [1:0]            cur_idx, cur_idx_d;
  logic [1:0]            tries, tries_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  we_d;
  logic [CNT_WIDTH-1:0]  count_d;

  function automatic logic [ADDR_WIDTH-1:0] cand_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    cand_addr = ADDR_WIDTH'(SPAWN_A);
      2'd1:    cand_addr = ADDR_WIDTH'(SPAWN_B);
      default: cand_addr = ADDR_WIDTH'(SPAWN_C);
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    next_idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Status pulses decode directly from the registered state.
  assign busy       = (state != S_IDLE);
  assign spawn_ack  = (state == S_WRITE);
  assign spawn_fail = (state == S_FAIL);

  // Next-state and next values of every registered output; the clear sweep uses wr_addr as its cursor.
  always_comb begin
    state_d   = state;
    rd_addr_d = rd_addr;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    we_d      = 1'b0;
    rr_ptr_d  = rr_ptr;
    cur_idx_d = cur_idx;
    tries_d   = tries;
    count_d   = enemy_count;
    if (kill && enemy_count != '0) begin
      count_d = enemy_count - 1'b1;
    end
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          we_d      = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end else if (spawn_req) begin
          if (enemy_count >= CNT_MAX) begin
            state_d = S_FAIL;
          end else begin
            rd_addr_d = cand_addr(rr_ptr);
            cur_idx_d = rr_ptr;
            tries_d   = 2'd0;
            state_d   = S_CHECK;
          end
        end
      end
      S_CLEAR: begin
        count_d = enemy_count;
        if (wr_addr == LAST_CELL) begin
          state_d  = S_IDLE;
          count_d  = '0;
          rr_ptr_d = 2'd0;
        end else begin
          we_d      = 1'b1;
          wr_addr_d = wr_addr + 1'b1;
        end
      end
      S_CHECK: begin
        if (rd_data == '0) begin
          wr_addr_d = rd_addr;
          wr_data_d = SPAWN_CODE;
          we_d      = 1'b1;
          state_d   = S_WRITE;
        end else if (tries == 2'd2) begin
          state_d = S_FAIL;
        end else begin
          tries_d   = tries + 2'd1;
          cur_idx_d = next_idx(cur_idx);
          rd_addr_d = cand_addr(next_idx(cur_idx));
        end
      end
      S_WRITE: begin
        rr_ptr_d = next_idx(cur_idx);
        state_d  = S_IDLE;
        if (kill) begin
          count_d = enemy_count;
        end else if (enemy_count < CNT_MAX) begin
          count_d = enemy_count + 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any sweep or spawn in progress.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_addr     <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      we          <= 1'b0;
      rr_ptr      <= 2'd0;
      cur_idx     <= 2'd0;
      tries       <= 2'd0;
      enemy_count <= '0;
    end else begin
      state       <= state_d;
      rd_addr     <= rd_addr_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      we          <= we_d;
      rr_ptr      <= rr_ptr_d;
      cur_idx     <= cur_idx_d;
      tries       <= tries_d;
      enemy_count <= count_d;
    end
  end

endmodule
